// File: rtl/riscv_pkg.sv
// Shared core definitions: instruction constants, exception width and
// memory-stage enums used by the load/store path.
package riscv_pkg;

    localparam int ILEN           = 32;
    localparam int EXCEPTION_SIZE = 16;

    localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [6:0]      OPC_LOAD  = 7'b000_0011;
    localparam logic [6:0]      OPC_STORE = 7'b010_0011;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HWORD = 2'd1,
        WORD  = 2'd2,
        DWORD = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } mem_state_e;

endpackage

// File: rtl/riscv_mem_ctrl.sv
// Data-memory request controller: owns the bus FSM and the registered
// request fields, and tells the stage when it may capture from EX.
module riscv_mem_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      wb_stall_i,
    input  logic                      ex_bubble_i,
    input  logic [EXCEPTION_SIZE-1:0] ex_exception_i,
    input  logic [6:0]                ex_opcode_i,
    input  logic [1:0]                ex_size_i,
    input  logic [XLEN-1:0]           ex_memadr_i,
    input  logic [XLEN-1:0]           ex_opb_i,
    input  logic                      dmem_ack_i,
    input  logic                      dmem_err_i,
    input  logic                      dmem_misaligned_i,
    input  logic                      dmem_page_fault_i,
    output logic                      capture_o,
    output logic                      drain_enter_o,
    output logic                      drain_o,
    output logic                      dmem_req_o,
    output logic [XLEN-1:0]           dmem_adr_o,
    output logic [2:0]                dmem_size_o,
    output logic                      dmem_we_o,
    output logic [XLEN-1:0]           dmem_d_o
);

    mem_state_e state_r;
    mem_state_e state_nxt_s;
    logic       resp_s;
    logic       memop_s;
    logic       capture_s;
    logic       load_req_s;
    logic       drain_enter_s;

    function automatic logic [XLEN-1:0] lane_replicate(input mem_size_e sz, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        r = d;
        case (sz)
            BYTE:    r = {(XLEN/8){d[7:0]}};
            HWORD:   r = {(XLEN/16){d[15:0]}};
            WORD:    r = {(XLEN/32){d[31:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    assign resp_s    = dmem_ack_i | dmem_err_i | dmem_misaligned_i | dmem_page_fault_i;
    assign memop_s   = ~ex_bubble_i & ~(|ex_exception_i) & ~flush_i &
                       ((ex_opcode_i == OPC_LOAD) | (ex_opcode_i == OPC_STORE));
    assign capture_s = ~wb_stall_i & (state_r != DRAIN);

    // Next-state logic and request-field load enable
    always_comb begin
        state_nxt_s   = state_r;
        load_req_s    = 1'b0;
        drain_enter_s = 1'b0;
        case (state_r)
            IDLE: begin
                load_req_s = capture_s;
                if (capture_s && memop_s) state_nxt_s = BUSY;
                else                      state_nxt_s = IDLE;
            end
            BUSY: begin
                if (resp_s) begin
                    load_req_s = capture_s;
                    if (capture_s && memop_s) state_nxt_s = BUSY;
                    else                      state_nxt_s = IDLE;
                end else if (flush_i) begin
                    // the outstanding access must stay on the bus until it answers
                    drain_enter_s = 1'b1;
                    state_nxt_s   = DRAIN;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DRAIN: begin
                if (resp_s) state_nxt_s = IDLE;
                else        state_nxt_s = DRAIN;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register and request-valid flop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= IDLE;
            dmem_req_o <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            dmem_req_o <= (state_nxt_s != IDLE);
        end
    end

    // Request payload, only reloaded when the bus is free to take a new access
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dmem_adr_o  <= '0;
            dmem_size_o <= 3'd0;
            dmem_we_o   <= 1'b0;
            dmem_d_o    <= '0;
        end else if (load_req_s) begin
            dmem_adr_o  <= ex_memadr_i;
            dmem_size_o <= {1'b0, ex_size_i};
            dmem_we_o   <= (ex_opcode_i == OPC_STORE);
            dmem_d_o    <= lane_replicate(mem_size_e'(ex_size_i), ex_opb_i);
        end
    end

    assign capture_o     = capture_s;
    assign drain_enter_o = drain_enter_s;
    assign drain_o       = (state_r == DRAIN);

endmodule

// File: rtl/riscv_mem.sv
// Memory-access pipeline stage: registers EX results for write-back and
// drives the data-memory request through riscv_mem_ctrl.
module riscv_mem
    import riscv_pkg::*;
#(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] PC_INIT = 32'h0000_0200
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    output logic                      mem_stall_o,
    input  logic                      flush_i,
    input  logic                      wb_stall_i,
    input  logic [XLEN-1:0]           ex_pc_i,
    input  logic [ILEN-1:0]           ex_instr_i,
    input  logic                      ex_bubble_i,
    input  logic [EXCEPTION_SIZE-1:0] ex_exception_i,
    input  logic [XLEN-1:0]           ex_r_i,
    input  logic [XLEN-1:0]           ex_memadr_i,
    input  logic [XLEN-1:0]           ex_opb_i,
    output logic [XLEN-1:0]           mem_pc_o,
    output logic [ILEN-1:0]           mem_instr_o,
    output logic                      mem_bubble_o,
    output logic [EXCEPTION_SIZE-1:0] mem_exception_o,
    output logic [XLEN-1:0]           mem_r_o,
    output logic [XLEN-1:0]           mem_memadr_o,
    output logic                      dmem_req_o,
    output logic [XLEN-1:0]           dmem_adr_o,
    output logic [2:0]                dmem_size_o,
    output logic                      dmem_we_o,
    output logic [XLEN-1:0]           dmem_d_o,
    input  logic                      dmem_ack_i,
    input  logic                      dmem_err_i,
    input  logic                      dmem_misaligned_i,
    input  logic                      dmem_page_fault_i
);

    logic capture_s;
    logic drain_enter_s;
    logic drain_s;

    riscv_mem_ctrl #(
        .XLEN (XLEN)
    ) u_ctrl (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .flush_i           (flush_i),
        .wb_stall_i        (wb_stall_i),
        .ex_bubble_i       (ex_bubble_i),
        .ex_exception_i    (ex_exception_i),
        .ex_opcode_i       (ex_instr_i[6:0]),
        .ex_size_i         (ex_instr_i[13:12]),
        .ex_memadr_i       (ex_memadr_i),
        .ex_opb_i          (ex_opb_i),
        .dmem_ack_i        (dmem_ack_i),
        .dmem_err_i        (dmem_err_i),
        .dmem_misaligned_i (dmem_misaligned_i),
        .dmem_page_fault_i (dmem_page_fault_i),
        .capture_o         (capture_s),
        .drain_enter_o     (drain_enter_s),
        .drain_o           (drain_s),
        .dmem_req_o        (dmem_req_o),
        .dmem_adr_o        (dmem_adr_o),
        .dmem_size_o       (dmem_size_o),
        .dmem_we_o         (dmem_we_o),
        .dmem_d_o          (dmem_d_o)
    );

    assign mem_stall_o = wb_stall_i | drain_s;

    // EX-to-WB pipeline registers; a flushed or drained slot becomes a bubble
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_pc_o        <= PC_INIT;
            mem_instr_o     <= INSTR_NOP;
            mem_bubble_o    <= 1'b1;
            mem_exception_o <= '0;
            mem_r_o         <= '0;
            mem_memadr_o    <= '0;
        end else begin
            if (capture_s) begin
                mem_pc_o        <= ex_pc_i;
                mem_instr_o     <= flush_i ? INSTR_NOP : ex_instr_i;
                mem_bubble_o    <= ex_bubble_i | flush_i;
                mem_exception_o <= ex_exception_i;
                mem_r_o         <= ex_r_i;
                mem_memadr_o    <= ex_memadr_i;
            end
            if (drain_enter_s) begin
                mem_bubble_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_mem.sv
// Randomised plus directed bench for riscv_mem against an in-bench
// transaction-level model of the memory stage.
module tb_riscv_mem;
    import riscv_pkg::*;

    localparam int XLEN = 32;

    logic                      clk = 1'b0;
    logic                      rst_ni = 1'b0;
    logic                      mem_stall_o, flush_i, wb_stall_i, ex_bubble_i;
    logic [XLEN-1:0]           ex_pc_i, ex_r_i, ex_memadr_i, ex_opb_i;
    logic [ILEN-1:0]           ex_instr_i;
    logic [EXCEPTION_SIZE-1:0] ex_exception_i;
    logic [XLEN-1:0]           mem_pc_o, mem_r_o, mem_memadr_o, dmem_adr_o, dmem_d_o;
    logic [ILEN-1:0]           mem_instr_o;
    logic                      mem_bubble_o, dmem_req_o, dmem_we_o;
    logic [EXCEPTION_SIZE-1:0] mem_exception_o;
    logic [2:0]                dmem_size_o;
    logic                      dmem_ack_i, dmem_err_i, dmem_misaligned_i, dmem_page_fault_i;

    riscv_mem #(.XLEN(XLEN), .PC_INIT(32'h0000_0200)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .mem_stall_o(mem_stall_o), .flush_i(flush_i),
        .wb_stall_i(wb_stall_i), .ex_pc_i(ex_pc_i), .ex_instr_i(ex_instr_i),
        .ex_bubble_i(ex_bubble_i), .ex_exception_i(ex_exception_i), .ex_r_i(ex_r_i),
        .ex_memadr_i(ex_memadr_i), .ex_opb_i(ex_opb_i), .mem_pc_o(mem_pc_o),
        .mem_instr_o(mem_instr_o), .mem_bubble_o(mem_bubble_o),
        .mem_exception_o(mem_exception_o), .mem_r_o(mem_r_o), .mem_memadr_o(mem_memadr_o),
        .dmem_req_o(dmem_req_o), .dmem_adr_o(dmem_adr_o), .dmem_size_o(dmem_size_o),
        .dmem_we_o(dmem_we_o), .dmem_d_o(dmem_d_o), .dmem_ack_i(dmem_ack_i),
        .dmem_err_i(dmem_err_i), .dmem_misaligned_i(dmem_misaligned_i),
        .dmem_page_fault_i(dmem_page_fault_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // model: architectural WB-facing state plus one outstanding bus transaction
    logic [31:0] m_pc, m_instr, m_r, m_adr;
    logic        m_bubble;
    logic [15:0] m_exc;
    bit          q_req, q_drain, q_we;
    logic [31:0] q_adr, q_d;
    logic [1:0]  q_size;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] exp_data(input logic [1:0] sz, input logic [31:0] opb);
        int bpl;
        logic [31:0] r;
        bpl = (sz >= 2'd2) ? 4 : (1 << sz);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = opb[8*(i % bpl) +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0000_0200; m_instr = INSTR_NOP; m_bubble = 1'b1;
        m_exc = 16'h0; m_r = 32'h0; m_adr = 32'h0;
        q_req = 1'b0; q_drain = 1'b0;
    endtask

    // one clock of the stage, evaluated from the present inputs
    task automatic model_step();
        bit resp, ld, st, memop, cap, issue;
        resp  = dmem_ack_i | dmem_err_i | dmem_misaligned_i | dmem_page_fault_i;
        ld    = (ex_instr_i[6:0] == OPC_LOAD);
        st    = (ex_instr_i[6:0] == OPC_STORE);
        memop = !ex_bubble_i && (ex_exception_i == 16'h0) && !flush_i && (ld || st);
        cap   = !wb_stall_i && !q_drain;
        issue = 1'b0;
        if (cap) begin
            m_pc = ex_pc_i; m_r = ex_r_i; m_adr = ex_memadr_i; m_exc = ex_exception_i;
            m_instr  = flush_i ? INSTR_NOP : ex_instr_i;
            m_bubble = ex_bubble_i || flush_i;
        end
        if (q_drain) begin
            if (resp) begin q_req = 1'b0; q_drain = 1'b0; end
        end else if (q_req) begin
            if (resp) begin
                q_req = 1'b0;
                issue = cap && memop;
            end else if (flush_i) begin
                q_drain = 1'b1; m_bubble = 1'b1;
            end
        end else begin
            issue = cap && memop;
        end
        if (issue) begin
            q_req = 1'b1; q_adr = ex_memadr_i; q_we = st;
            q_size = ex_instr_i[13:12];
            q_d = exp_data(ex_instr_i[13:12], ex_opb_i);
        end
    endtask

    task automatic compare_all();
        chk("mem_pc", mem_pc_o, m_pc);
        chk("mem_instr", mem_instr_o, m_instr);
        chk("mem_bubble", mem_bubble_o, m_bubble);
        chk("mem_exception", mem_exception_o, m_exc);
        chk("mem_r", mem_r_o, m_r);
        chk("mem_memadr", mem_memadr_o, m_adr);
        chk("dmem_req", dmem_req_o, q_req);
        if (q_req) begin
            chk("dmem_adr", dmem_adr_o, q_adr);
            chk("dmem_size", dmem_size_o, {1'b0, q_size});
            chk("dmem_we", dmem_we_o, q_we);
            chk("dmem_d", dmem_d_o, q_d);
        end
    endtask

    // inputs are applied just after a falling edge; returns at the next falling edge
    task automatic cycle();
        #1;
        chk("mem_stall", mem_stall_o, wb_stall_i | q_drain);
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic set_ex(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] adr,
                          input logic [31:0] opb, input logic bub, input logic [15:0] exc);
        logic [31:0] rnd;
        rnd = $urandom();
        ex_instr_i = {rnd[31:15], f3, rnd[11:7], opc};
        ex_pc_i = $urandom(); ex_r_i = $urandom();
        ex_memadr_i = adr; ex_opb_i = opb; ex_bubble_i = bub; ex_exception_i = exc;
    endtask

    task automatic set_ctl(input logic fl, input logic st, input logic ack);
        flush_i = fl; wb_stall_i = st; dmem_ack_i = ack;
        dmem_err_i = 1'b0; dmem_misaligned_i = 1'b0; dmem_page_fault_i = 1'b0;
    endtask

    task automatic rand_inputs();
        int unsigned k;
        bit resp;
        logic [6:0] opc;
        k = $urandom_range(0, 3);
        opc = (k == 0) ? OPC_LOAD : (k == 1) ? OPC_STORE : (k == 2) ? 7'h33 : 7'($urandom());
        set_ex(opc, 3'($urandom()), $urandom(), $urandom(),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0) ? 16'($urandom()) : 16'h0);
        resp = q_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
        set_ctl(($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0), 1'b0);
        k = $urandom_range(0, 3);
        dmem_ack_i = resp && (k == 0); dmem_err_i = resp && (k == 1);
        dmem_misaligned_i = resp && (k == 2); dmem_page_fault_i = resp && (k == 3);
        // write-back holds the stage while an access is still open
        if (q_req && !q_drain && !resp && !flush_i) wb_stall_i = 1'b1;
    endtask

    initial begin
        model_reset();
        set_ctl(1'b0, 1'b0, 1'b0);
        set_ex(7'h33, 3'd0, 32'h0, 32'h0, 1'b1, 16'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc", mem_pc_o, 32'h200);
        chk("rst_instr", mem_instr_o, 32'h13);
        chk("rst_bubble", mem_bubble_o, 1'b1);
        chk("rst_req", dmem_req_o, 1'b0);
        compare_all();
        @(negedge clk);
        rst_ni = 1'b1;

        // LW, acknowledged on the third request cycle
        set_ex(OPC_LOAD, 3'b010, 32'h1004, 32'h0, 1'b0, 16'h0);
        cycle();
        chk("lw_req", dmem_req_o, 1'b1);
        chk("lw_adr", dmem_adr_o, 32'h1004);
        chk("lw_size", dmem_size_o, 3'd2);
        chk("lw_we", dmem_we_o, 1'b0);
        set_ex(7'h33, 3'd0, 32'h0, 32'h0, 1'b1, 16'h0);
        set_ctl(1'b0, 1'b1, 1'b0);
        cycle(); cycle();
        chk("lw_hold", dmem_req_o, 1'b1);
        set_ctl(1'b0, 1'b0, 1'b1);
        cycle();
        chk("lw_done", dmem_req_o, 1'b0);

        // SB with lane replication, held across stall cycles
        set_ctl(1'b0, 1'b0, 1'b0);
        set_ex(OPC_STORE, 3'b000, 32'h2001, 32'h0000_00A5, 1'b0, 16'h0);
        cycle();
        chk("sb_d", dmem_d_o, 32'hA5A5_A5A5);
        chk("sb_size", dmem_size_o, 3'd0);
        chk("sb_we", dmem_we_o, 1'b1);
        set_ex(7'h33, 3'd0, 32'h0, 32'h0, 1'b1, 16'h0);
        set_ctl(1'b0, 1'b1, 1'b0);
        cycle(); cycle();
        chk("sb_d_hold", dmem_d_o, 32'hA5A5_A5A5);
        set_ctl(1'b0, 1'b0, 1'b1);
        cycle();

        // back-to-back LW then SW, no idle gap
        set_ctl(1'b0, 1'b0, 1'b0);
        set_ex(OPC_LOAD, 3'b010, 32'h2000, 32'h0, 1'b0, 16'h0);
        cycle();
        set_ex(OPC_STORE, 3'b010, 32'h3000, 32'h1234_5678, 1'b0, 16'h0);
        set_ctl(1'b0, 1'b0, 1'b1);
        cycle();
        chk("b2b_req", dmem_req_o, 1'b1);
        chk("b2b_adr", dmem_adr_o, 32'h3000);
        chk("b2b_we", dmem_we_o, 1'b1);
        set_ex(7'h33, 3'd0, 32'h0, 32'h0, 1'b1, 16'h0);
        cycle();

        // flush while busy: drain the killed load, no new request
        set_ctl(1'b0, 1'b0, 1'b0);
        set_ex(OPC_LOAD, 3'b010, 32'h4000, 32'h0, 1'b0, 16'h0);
        cycle();
        set_ctl(1'b1, 1'b0, 1'b0);
        set_ex(OPC_LOAD, 3'b010, 32'h5000, 32'h0, 1'b0, 16'h0);
        cycle();
        chk("drain_stall", mem_stall_o, 1'b1);
        chk("drain_bubble", mem_bubble_o, 1'b1);
        set_ctl(1'b0, 1'b0, 1'b0);
        set_ex(OPC_LOAD, 3'b010, 32'h6000, 32'h0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("drain_adr", dmem_adr_o, 32'h4000);
        end
        set_ctl(1'b0, 1'b0, 1'b1);
        cycle();
        chk("drain_done", dmem_req_o, 1'b0);

        // exception or bubble suppresses the request
        set_ctl(1'b0, 1'b0, 1'b0);
        set_ex(OPC_LOAD, 3'b010, 32'h7000, 32'h0, 1'b0, 16'h0004);
        cycle();
        chk("exc_req", dmem_req_o, 1'b0);
        chk("exc_copy", mem_exception_o, 16'h0004);
        set_ex(OPC_LOAD, 3'b010, 32'h7000, 32'h0, 1'b1, 16'h0);
        cycle();
        chk("bub_req", dmem_req_o, 1'b0);

        // asynchronous reset in the middle of a request
        set_ex(OPC_LOAD, 3'b010, 32'h8000, 32'h0, 1'b0, 16'h0);
        cycle();
        set_ctl(1'b0, 1'b1, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_req", dmem_req_o, 1'b0);
        chk("arst_bubble", mem_bubble_o, 1'b1);
        chk("arst_pc", mem_pc_o, 32'h200);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;

        for (int n = 0; n < 2000; n++) begin
            rand_inputs();
            cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
